lcg_rr_arbiter: RTL
===================

Name: lcg_rr_arbiter

Overview:
Shared 16-bit linear congruential random number source, arbitrated round-robin between NREQ requesters.
- Owns the LCG state register and sequences it through a post-reset/post-reseed warm-up phase.
- Accepts runtime reseed commands.
- Hands out exactly one fresh value per grant, so no two requesters ever receive the same draw.
- Sits between the randomness consumers (test-pattern, jitter, scrambler blocks) and the RNG datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
A, 22697, LCG multiplier
C, 1, LCG increment
SEED_RST, 16'h1234, state value loaded on reset
WARMUP, 4, LCG advances discarded after reset/reseed before serving (0..255)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
req  input  NREQ  per-requester level request; held until its gnt bit is seen
seed_load  input  1  single-cycle reseed strobe
seed_in  input  16  seed value, sampled when seed_load=1
gnt  output  NREQ  one-hot grant, single-cycle pulse
rand_out  output  16  value belonging to the current grant
rand_valid  output  1  high exactly when gnt is non-zero
busy  output  1  high while not in SERVE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on the rising edge of clk.
- LCG step: next = (A*state + C) mod 2^16. Compute the product at 32 bits and keep the low 16 bits. No other modulus is permitted.
- Reset values:
  - state=SEED_RST, fsm=WARM, warm_cnt=WARMUP (if WARMUP=0, fsm=SERVE)
  - gnt=0, rand_valid=0, rand_out=0
  - busy=1 (0 if WARMUP=0)
  - rr pointer ptr=0
- FSM states: WARM, SERVE.
- WARM:
  - Each cycle: state<=next, warm_cnt<=warm_cnt-1. No grants; req is ignored but not lost.
  - When warm_cnt==1 at the edge, go to SERVE. busy falls on that same edge, i.e. exactly WARMUP cycles after reset deasserts.
- SERVE:
  - If any req bit is set, the winner is the first set bit scanning ptr, ptr+1, ... mod NREQ.
  - Registered on the edge: gnt<=onehot(winner), rand_out<=state, rand_valid<=1, state<=next, ptr<=(winner+1) mod NREQ.
  - If no req: gnt=0, rand_valid=0, rand_out holds its last value, state holds (the LCG does not free-run).
- Latency: req sampled at edge k; gnt/rand_out are visible during cycle k..k+1, i.e. one-cycle registered latency.
- Requester handshake: the requester must drop req in the cycle it sees gnt, or it re-enters arbitration.
- Throughput: one grant per cycle maximum. A continuously requesting requester waits at most NREQ-1 grants to others.
- Reseed:
  - seed_load=1 (any state) at an edge: state<=seed_in, warm_cnt<=WARMUP, fsm<=WARM (SERVE if WARMUP=0), gnt<=0, rand_valid<=0.
  - seed_load has priority over any req in the same cycle. That request is not granted and must stay asserted.
  - ptr is unchanged by a reseed.
- Reseed during WARM restarts the warm-up from seed_in.
- rst has priority over seed_load and req. A mid-operation reset discards any grant being issued that cycle.
- No X on outputs after the first reset edge.

Test Plan:
1. Default params, rst held 2 cycles then released, req=0 -> busy=1 for exactly 4 cycles then 0. gnt stays 0 throughout.
2. WARMUP=0, req=4'b0001 held 3 cycles -> three consecutive gnt=0001 pulses with rand_out=0x1234, 0xE455, 0xF41E.
3. WARMUP=0, req=4'b1111 held 8 cycles from reset -> gnt sequence 0001,0010,0100,1000,0001,... and rand_out matches consecutive LCG values with none repeated.
4. WARMUP=0, req=4'b1010 with ptr=0 -> gnt=0010 then 1000 then 0010. A requester that drops req after its grant is skipped.
5. WARMUP=0, seed_in=0, seed_load pulsed while req=0001:
   - no grant in the seed_load cycle
   - next grants return 0x0000, 0x0001, 0x58AA (22698)
6. Default params, seed_load pulsed mid-WARM, and separately rst asserted in a cycle with req active:
   - seed_load mid-WARM: busy extends by a full 4 cycles after the seed_load edge
   - rst case: gnt=0, rand_valid=0 next cycle, state back to 0x1234

Source files
------------

// File: rtl/lcg_rr_arbiter_if.sv
// Request/grant bundle between the randomness consumers and the shared LCG arbiter.
// Handshake: req[i] is a level held by requester i until it observes gnt[i]; gnt is a
// single-cycle one-hot pulse carrying rand_out, and the requester drops req in that cycle.
interface lcg_rr_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0] req;
   logic            seed_load;
   logic [15:0]     seed_in;
   logic [NREQ-1:0] gnt;
   logic [15:0]     rand_out;
   logic            rand_valid;
   logic            busy;

   modport master (
      output req, seed_load, seed_in,
      input  gnt, rand_out, rand_valid, busy
   );

   modport slave (
      input  req, seed_load, seed_in,
      output gnt, rand_out, rand_valid, busy
   );
endinterface

// File: rtl/lcg_rr_arbiter.sv
// Shared 16-bit LCG source with warm-up after reset/reseed, handing one fresh draw
// per grant to NREQ round-robin requesters.
module lcg_rr_arbiter #(
   parameter int          NREQ     = 4,
   parameter int          A        = 22697,
   parameter int          C        = 1,
   parameter logic [15:0] SEED_RST = 16'h1234,
   parameter int          WARMUP   = 4
) (
   input  logic                clk,
   input  logic                rst,
   lcg_rr_arbiter_if.slave     bus,
   output logic                dbg_serve,
   output logic [15:0]         dbg_state
);
   localparam int              PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [31:0]     A32       = 32'(A);
   localparam logic [31:0]     C32       = 32'(C);
   localparam logic [7:0]      WARM_INIT = 8'(WARMUP);
   localparam logic [PW:0]     NREQ_W    = (PW+1)'(NREQ);
   localparam logic [PW-1:0]   LAST      = PW'(NREQ - 1);

   typedef enum logic {WARM, SERVE} fsm_t;
   localparam fsm_t FSM_INIT = (WARMUP == 0) ? SERVE : WARM;

   fsm_t            fsm_q, fsm_d;
   logic [7:0]      warm_q, warm_d;
   logic [15:0]     lcg_q, lcg_d, lcg_next;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [15:0]     rout_q, rout_d;
   logic            rv_q, rv_d;

   logic            any_req;
   logic [PW-1:0]   winner;
   logic [PW:0]     scan_sum;
   logic [PW-1:0]   scan_idx;

   // Product formed at 32 bits; only the low half is the mod 2^16 result.
   always_comb begin
      lcg_next = 16'(A32 * {16'b0, lcg_q} + C32);
   end

   // First requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      any_req  = 1'b0;
      winner   = '0;
      scan_sum = '0;
      scan_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         scan_sum = {1'b0, ptr_q} + (PW+1)'(i);
         if (scan_sum >= NREQ_W) scan_sum = scan_sum - NREQ_W;
         scan_idx = scan_sum[PW-1:0];
         if (!any_req && bus.req[scan_idx]) begin
            any_req = 1'b1;
            winner  = scan_idx;
         end
      end
   end

   always_comb begin
      fsm_d  = fsm_q;
      warm_d = warm_q;
      lcg_d  = lcg_q;
      ptr_d  = ptr_q;
      gnt_d  = '0;
      rv_d   = 1'b0;
      rout_d = rout_q;
      if (bus.seed_load) begin
         // Reseed wins over any request; ptr is deliberately left alone.
         lcg_d  = bus.seed_in;
         warm_d = WARM_INIT;
         fsm_d  = FSM_INIT;
      end else begin
         unique case (fsm_q)
            WARM: begin
               lcg_d  = lcg_next;
               warm_d = warm_q - 8'd1;
               if (warm_q == 8'd1) fsm_d = SERVE;
            end
            SERVE: begin
               if (any_req) begin
                  gnt_d         = '0;
                  gnt_d[winner] = 1'b1;
                  rv_d          = 1'b1;
                  rout_d        = lcg_q;
                  lcg_d         = lcg_next;
                  ptr_d         = (winner == LAST) ? '0 : winner + PW'(1);
               end
            end
            default: fsm_d = FSM_INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q  <= FSM_INIT;
         warm_q <= WARM_INIT;
         lcg_q  <= SEED_RST;
         ptr_q  <= '0;
         gnt_q  <= '0;
         rout_q <= '0;
         rv_q   <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         warm_q <= warm_d;
         lcg_q  <= lcg_d;
         ptr_q  <= ptr_d;
         gnt_q  <= gnt_d;
         rout_q <= rout_d;
         rv_q   <= rv_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.rand_out   = rout_q;
   assign bus.rand_valid = rv_q;
   assign bus.busy       = (fsm_q != SERVE);
   assign dbg_serve      = (fsm_q == SERVE);
   assign dbg_state      = lcg_q;

   a_gnt_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
   a_valid_gnt  : assert property (@(posedge clk) disable iff (rst) rv_q == (gnt_q != '0));
   a_warm_quiet : assert property (@(posedge clk) disable iff (rst) (fsm_q == WARM) |-> (gnt_q == '0));
   a_ptr_range  : assert property (@(posedge clk) disable iff (rst) {1'b0, ptr_q} < NREQ_W);
endmodule
